// File: rtl/alu_n_pkg.sv
// Shared opcodes, FSM state type and opcode
// predicates for the digit-serial ALU.
package alu_n_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_ADC = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  localparam logic [3:0] OP_NEG = 4'd9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_sub(
    input logic [3:0] op
  );
    return op == OP_SUB || op == OP_SBC ||
           op == OP_CMP || op == OP_NEG;
  endfunction

  function automatic logic uses_carry(
    input logic [3:0] op
  );
    return op == OP_ADC || op == OP_SBC;
  endfunction

  function automatic logic is_arith(
    input logic [3:0] op
  );
    return op <= OP_SBC || op == OP_CMP ||
           op == OP_NEG;
  endfunction

  function automatic logic is_logic(
    input logic [3:0] op
  );
    return op == OP_AND || op == OP_OR ||
           op == OP_XOR;
  endfunction

  function automatic logic is_valid(
    input logic [3:0] op
  );
    return op <= OP_NEG;
  endfunction

  function automatic logic writes_result(
    input logic [3:0] op
  );
    return op <= OP_MOV || op == OP_NEG;
  endfunction

endpackage

// File: rtl/alu_n_digit.sv
// Combinational datapath for one digit:
// arg2 extension, inversion, add, logic ops.
module alu_n_digit
  import alu_n_pkg::*;
#(
  parameter int NSHIFT = 2
) (
  input  logic [3:0]        op,
  input  logic [NSHIFT-1:0] a,
  input  logic [NSHIFT-1:0] b,
  input  logic              ext,
  input  logic              fill,
  input  logic              cin,
  output logic [NSHIFT-1:0] res,
  output logic              cout,
  output logic              ovf
);

  logic [NSHIFT-1:0] b_x;
  logic [NSHIFT-1:0] a_x;
  logic [NSHIFT-1:0] b_y;
  logic [NSHIFT:0]   sum;
  logic [NSHIFT-1:0] low;

  // Extend, invert and add; carry into msb gives V
  always_comb begin
    b_x = ext ? {NSHIFT{fill}} : b;
    a_x = (op == OP_NEG) ? '0 : a;
    b_y = is_sub(op) ? ~b_x : b_x;
    sum = {1'b0, a_x} + {1'b0, b_y}
        + {{NSHIFT{1'b0}}, cin};
    low = {1'b0, a_x[NSHIFT-2:0]}
        + {1'b0, b_y[NSHIFT-2:0]}
        + {{(NSHIFT-1){1'b0}}, cin};
    cout = sum[NSHIFT];
    ovf  = low[NSHIFT-1] ^ sum[NSHIFT];
  end

  // Result select by opcode class
  always_comb begin
    res = '0;
    unique case (1'b1)
      is_arith(op):     res = sum[NSHIFT-1:0];
      (op == OP_AND):   res = a & b_x;
      (op == OP_OR):    res = a | b_x;
      (op == OP_XOR):   res = a ^ b_x;
      (op == OP_MOV):   res = b_x;
      default:          res = '0;
    endcase
  end

endmodule

// File: rtl/serial_alu_n.sv
// Digit-serial ALU: op handshake, digit counter,
// running carry/sign/zero and atomic flag commit.
module serial_alu_n
  import alu_n_pkg::*;
#(
  parameter int NSHIFT     = 2,
  parameter int REG_BITS   = 8,
  parameter int MAX_BYTES  = 4,
  parameter int BYTES_BITS =
    (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1,
  parameter int CNT_BITS   =
    $clog2(MAX_BYTES * REG_BITS / NSHIFT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [3:0]            op,
  input  logic [BYTES_BITS-1:0] len1,
  input  logic [BYTES_BITS-1:0] len2,
  input  logic                  sext2,
  input  logic [1:0]            flag_mask,
  input  logic                  advance,
  input  logic [NSHIFT-1:0]     data_in1,
  input  logic [NSHIFT-1:0]     data_in2,
  output logic [NSHIFT-1:0]     data_out,
  output logic                  result_we,
  output logic                  op_done,
  output logic [CNT_BITS-1:0]   counter,
  output logic                  flag_c,
  output logic                  flag_v,
  output logic                  flag_s,
  output logic                  flag_z
);

  localparam int DPB = REG_BITS / NSHIFT;

  state_t                state;
  logic [CNT_BITS-1:0]   cnt;
  logic [3:0]            op_q;
  logic [BYTES_BITS-1:0] len1_q;
  logic [BYTES_BITS-1:0] len2_q;
  logic                  sext2_q;
  logic [1:0]            mask_q;
  logic                  carry_q;
  logic                  sign_q;
  logic                  z_q;

  logic [CNT_BITS-1:0]   last_idx;
  logic [CNT_BITS-1:0]   last2_idx;
  logic [CNT_BITS-1:0]   byte_idx;
  logic                  ext;
  logic                  cin;
  logic                  cout;
  logic                  ovf;
  logic [NSHIFT-1:0]     res;
  logic                  run;
  logic                  step;
  logic                  is_last;
  logic                  accept;
  logic                  z_run;
  logic                  z_new;

  assign run       = (state == RUN);
  assign step      = run && advance;
  assign last_idx  =
    CNT_BITS'((int'(len1_q) + 1) * DPB - 1);
  assign last2_idx =
    CNT_BITS'((int'(len2_q) + 1) * DPB - 1);
  assign byte_idx  = cnt / CNT_BITS'(DPB);
  assign is_last   = (cnt == last_idx);
  assign ext       = byte_idx > CNT_BITS'(len2_q);
  assign cin       = (cnt != '0) ? carry_q :
                     uses_carry(op_q) ? flag_c :
                     is_sub(op_q);
  assign z_run     = ((cnt == '0) ? 1'b1 : z_q)
                   & (res == '0);
  assign z_new     = z_run &
                     (uses_carry(op_q) ? flag_z : 1'b1);

  assign op_done   = step && is_last;
  assign op_ready  = !run || op_done;
  assign accept    = op_valid && op_ready;
  assign result_we = step && writes_result(op_q);
  assign data_out  = res;
  assign counter   = cnt;

  alu_n_digit #(
    .NSHIFT (NSHIFT)
  ) u_digit (
    .op   (op_q),
    .a    (data_in1),
    .b    (data_in2),
    .ext  (ext),
    .fill (sext2_q & sign_q),
    .cin  (cin),
    .res  (res),
    .cout (cout),
    .ovf  (ovf)
  );

  // FSM, operand latch and per-digit state
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      len1_q  <= '0;
      len2_q  <= '0;
      sext2_q <= 1'b0;
      mask_q  <= '0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      if (step) begin
        carry_q <= cout;
        z_q     <= z_run;
        if (cnt == last2_idx)
          sign_q <= data_in2[NSHIFT-1];
        cnt <= is_last ? '0 : cnt + 1'b1;
        if (is_last && !accept)
          state <= IDLE;
      end
      if (accept) begin
        state   <= RUN;
        cnt     <= '0;
        op_q    <= op;
        len1_q  <= len1;
        len2_q  <= (len2 > len1) ? len1 : len2;
        sext2_q <= sext2;
        mask_q  <= flag_mask;
      end
    end
  end

  // Flag commit on the last digit edge
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      flag_s <= 1'b0;
      flag_z <= 1'b0;
    end else if (op_done && is_valid(op_q)) begin
      if (mask_q[0] && op_q != OP_MOV) begin
        flag_c <= is_logic(op_q) ? 1'b0 : cout;
        flag_v <= is_logic(op_q) ? 1'b0 : ovf;
      end
      if (mask_q[1]) begin
        flag_s <= res[NSHIFT-1];
        flag_z <= z_new;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_n.sv
// Directed self-checking bench for the
// digit-serial ALU (NSHIFT=2, 8-bit lanes).
module tb_serial_alu_n;
  import alu_n_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op = '0;
  logic [1:0] len1 = '0;
  logic [1:0] len2 = '0;
  logic       sext2 = 1'b0;
  logic [1:0] flag_mask = '0;
  logic       advance = 1'b0;
  logic [1:0] data_in1 = '0;
  logic [1:0] data_in2 = '0;
  logic [1:0] data_out;
  logic       result_we;
  logic       op_done;
  logic [3:0] counter;
  logic       flag_c, flag_v, flag_s, flag_z;

  int checks = 0;
  int errors = 0;

  serial_alu_n dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .len1      (len1),
    .len2      (len2),
    .sext2     (sext2),
    .flag_mask (flag_mask),
    .advance   (advance),
    .data_in1  (data_in1),
    .data_in2  (data_in2),
    .data_out  (data_out),
    .result_we (result_we),
    .op_done   (op_done),
    .counter   (counter),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_s    (flag_s),
    .flag_z    (flag_z)
  );

  always #5 clk = ~clk;

  // Issue one op from IDLE and stream all digits
  task automatic run_op(
    input  logic [3:0]  o,
    input  logic [1:0]  l1,
    input  logic [1:0]  l2,
    input  logic        s2,
    input  logic [1:0]  m,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output int          we_cnt,
    output int          done_at
  );
    int n;
    n = (int'(l1) + 1) * 4;
    res = '0;
    we_cnt = 0;
    done_at = -1;
    @(negedge clk);
    op_valid = 1'b1;
    op = o;
    len1 = l1;
    len2 = l2;
    sext2 = s2;
    flag_mask = m;
    advance = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: got %b want 1",
               op_ready);
    end
    @(negedge clk);
    op_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      advance = 1'b1;
      data_in1 = a[2*i +: 2];
      data_in2 = b[2*i +: 2];
      #1;
      res[2*i +: 2] = data_out;
      if (result_we === 1'b1) we_cnt++;
      if (op_done === 1'b1 && done_at < 0)
        done_at = i;
      @(negedge clk);
    end
    advance = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({op_ready, op_done, result_we} !== 3'b100
        || counter !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b done=%b we=%b cnt=%0d want 1 0 0 0",
               op_ready, op_done, result_we, counter);
    end
    checks++;
    if ({flag_c, flag_v, flag_s, flag_z} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {flag_c, flag_v, flag_s, flag_z});
    end
    reset = 1'b0;
  endtask

  task automatic test_add_overflow();
    logic [31:0] r;
    int we, dn;
    run_op(OP_ADD, 2'd0, 2'd0, 1'b0, 2'd3,
           32'h7F, 32'h01, r, we, dn);
    checks++;
    if (r[7:0] !== 8'h80) begin
      errors++;
      $display("FAIL add_result: got %h want 80", r[7:0]);
    end
    checks++;
    if (dn !== 3 || we !== 4) begin
      errors++;
      $display("FAIL add_done: done_at=%0d we=%0d want 3 4",
               dn, we);
    end
    checks++;
    if ({flag_c, flag_v, flag_s, flag_z} !== 4'b0110) begin
      errors++;
      $display("FAIL add_flags: cvsz got %b want 0110",
               {flag_c, flag_v, flag_s, flag_z});
    end
  endtask

  task automatic test_sext();
    logic [31:0] r;
    int we, dn;
    run_op(OP_ADD, 2'd1, 2'd0, 1'b1, 2'd3,
           32'h1234, 32'h00FF, r, we, dn);
    checks++;
    if (r[15:0] !== 16'h1233) begin
      errors++;
      $display("FAIL sext_result: got %h want 1233", r[15:0]);
    end
    checks++;
    if ({flag_c, flag_v, flag_s, flag_z} !== 4'b1000) begin
      errors++;
      $display("FAIL sext_flags: cvsz got %b want 1000",
               {flag_c, flag_v, flag_s, flag_z});
    end
  endtask

  task automatic test_chain();
    logic [31:0] r;
    int we, dn;
    run_op(OP_SUB, 2'd1, 2'd1, 1'b0, 2'd3,
           32'h0000, 32'h0001, r, we, dn);
    checks++;
    if (r[15:0] !== 16'hFFFF ||
        {flag_c, flag_v, flag_s, flag_z} !== 4'b0010) begin
      errors++;
      $display("FAIL sub16: got %h cvsz=%b want FFFF 0010",
               r[15:0], {flag_c, flag_v, flag_s, flag_z});
    end
    run_op(OP_SBC, 2'd0, 2'd0, 1'b0, 2'd3,
           32'h00, 32'h00, r, we, dn);
    checks++;
    if (r[7:0] !== 8'hFF ||
        {flag_c, flag_v, flag_s, flag_z} !== 4'b0010) begin
      errors++;
      $display("FAIL sbc_borrow: got %h cvsz=%b want FF 0010",
               r[7:0], {flag_c, flag_v, flag_s, flag_z});
    end
    run_op(OP_ADD, 2'd0, 2'd0, 1'b0, 2'd3,
           32'h00, 32'h00, r, we, dn);
    run_op(OP_ADC, 2'd0, 2'd0, 1'b0, 2'd3,
           32'h00, 32'h00, r, we, dn);
    checks++;
    if (r[7:0] !== 8'h00 || flag_z !== 1'b1 ||
        flag_c !== 1'b0) begin
      errors++;
      $display("FAIL adc_z_chain1: got %h z=%b c=%b want 00 1 0",
               r[7:0], flag_z, flag_c);
    end
    run_op(OP_ADD, 2'd0, 2'd0, 1'b0, 2'd3,
           32'h01, 32'h00, r, we, dn);
    run_op(OP_ADC, 2'd0, 2'd0, 1'b0, 2'd3,
           32'h00, 32'h00, r, we, dn);
    checks++;
    if (r[7:0] !== 8'h00 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL adc_z_chain0: got %h z=%b want 00 0",
               r[7:0], flag_z);
    end
  endtask

  task automatic test_neg_mov();
    logic [31:0] r;
    int we, dn;
    run_op(OP_NEG, 2'd0, 2'd0, 1'b0, 2'd3,
           32'hAA, 32'h01, r, we, dn);
    checks++;
    if (r[7:0] !== 8'hFF ||
        {flag_c, flag_v, flag_s, flag_z} !== 4'b0010) begin
      errors++;
      $display("FAIL neg1: got %h cvsz=%b want FF 0010",
               r[7:0], {flag_c, flag_v, flag_s, flag_z});
    end
    run_op(OP_NEG, 2'd0, 2'd0, 1'b0, 2'd3,
           32'h55, 32'h00, r, we, dn);
    run_op(OP_MOV, 2'd0, 2'd0, 1'b0, 2'd3,
           32'h55, 32'h80, r, we, dn);
    checks++;
    if (r[7:0] !== 8'h80 ||
        {flag_c, flag_v, flag_s, flag_z} !== 4'b1010) begin
      errors++;
      $display("FAIL mov_keep_c: got %h cvsz=%b want 80 1010",
               r[7:0], {flag_c, flag_v, flag_s, flag_z});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a1, b1, a2, b2, r1, r2;
    int we;
    a1 = 8'h11; b1 = 8'h22;
    a2 = 8'h0F; b2 = 8'hFF;
    r1 = '0; r2 = '0; we = 0;
    @(negedge clk);
    op_valid = 1'b1;
    op = OP_ADD; len1 = 0; len2 = 0;
    sext2 = 0; flag_mask = 2'd3;
    @(negedge clk);
    op = OP_XOR; flag_mask = 2'd2;
    for (int i = 0; i < 4; i++) begin
      advance = 1'b1;
      data_in1 = a1[2*i +: 2];
      data_in2 = b1[2*i +: 2];
      #1;
      r1[2*i +: 2] = data_out;
      if (result_we === 1'b1) we++;
      if (i == 3) begin
        checks++;
        if (op_ready !== 1'b1 || op_done !== 1'b1) begin
          errors++;
          $display("FAIL b2b_handoff: rdy=%b done=%b want 1 1",
                   op_ready, op_done);
        end
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      advance = 1'b1;
      data_in1 = a2[2*i +: 2];
      data_in2 = b2[2*i +: 2];
      #1;
      r2[2*i +: 2] = data_out;
      if (result_we === 1'b1) we++;
      if (i == 0) begin
        checks++;
        if (counter !== 4'd0 || op_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_second_run: cnt=%0d rdy=%b want 0 0",
                   counter, op_ready);
        end
      end
      @(negedge clk);
    end
    advance = 1'b0;
    checks++;
    if (r1 !== 8'h33 || r2 !== 8'hF0 || we !== 8) begin
      errors++;
      $display("FAIL b2b_results: r1=%h r2=%h we=%0d want 33 F0 8",
               r1, r2, we);
    end
    checks++;
    if (flag_s !== 1'b1 || flag_z !== 1'b0 ||
        op_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_flags: s=%b z=%b rdy=%b want 1 0 1",
               flag_s, flag_z, op_ready);
    end
  endtask

  task automatic test_stall();
    logic [7:0] a, b, r;
    a = 8'h3C; b = 8'h05; r = '0;
    @(negedge clk);
    op_valid = 1'b1;
    op = OP_ADD; len1 = 0; len2 = 0;
    sext2 = 0; flag_mask = 2'd0;
    @(negedge clk);
    op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        advance = 1'b0;
        data_in1 = a[5:4];
        data_in2 = b[5:4];
        #1;
        checks++;
        if (counter !== 4'd2 || result_we !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: cnt=%0d we=%b want 2 0",
                   counter, result_we);
        end
        @(negedge clk);
        #1;
        checks++;
        if (counter !== 4'd2) begin
          errors++;
          $display("FAIL stall_cnt: got %0d want 2", counter);
        end
      end
      advance = 1'b1;
      data_in1 = a[2*i +: 2];
      data_in2 = b[2*i +: 2];
      #1;
      r[2*i +: 2] = data_out;
      @(negedge clk);
    end
    advance = 1'b0;
    checks++;
    if (r !== 8'h41) begin
      errors++;
      $display("FAIL stall_result: got %h want 41", r);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r;
    int we, dn;
    @(negedge clk);
    op_valid = 1'b1;
    op = OP_CMP; len1 = 0; len2 = 0;
    sext2 = 0; flag_mask = 2'd3;
    @(negedge clk);
    op_valid = 1'b0;
    advance = 1'b1;
    data_in1 = 2'd1; data_in2 = 2'd3;
    repeat (2) @(negedge clk);
    advance = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (op_ready !== 1'b1 || counter !== 4'd0 ||
        {flag_c, flag_v, flag_s, flag_z} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b cnt=%0d cvsz=%b want 1 0 0000",
               op_ready, counter,
               {flag_c, flag_v, flag_s, flag_z});
    end
    run_op(OP_CMP, 2'd0, 2'd0, 1'b0, 2'd3,
           32'h05, 32'h05, r, we, dn);
    checks++;
    if (we !== 0 ||
        {flag_c, flag_v, flag_s, flag_z} !== 4'b1001) begin
      errors++;
      $display("FAIL cmp_eq: we=%0d cvsz=%b want 0 1001",
               we, {flag_c, flag_v, flag_s, flag_z});
    end
  endtask

  task automatic test_reserved();
    logic [31:0] r;
    int we, dn;
    run_op(4'hF, 2'd3, 2'd3, 1'b0, 2'd3,
           32'hDEADBEEF, 32'h12345678, r, we, dn);
    checks++;
    if (r !== 32'h0 || we !== 0 || dn !== 15) begin
      errors++;
      $display("FAIL reserved_run: r=%h we=%0d done_at=%0d want 0 0 15",
               r, we, dn);
    end
    checks++;
    if ({flag_c, flag_v, flag_s, flag_z} !== 4'b1001) begin
      errors++;
      $display("FAIL reserved_flags: cvsz got %b want 1001",
               {flag_c, flag_v, flag_s, flag_z});
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sext();
    test_chain();
    test_neg_mov();
    test_back_to_back();
    test_stall();
    test_reset_mid_op();
    test_reserved();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
